// File: rtl/issue_hazard_ctrl.sv
// issue_hazard_ctrl: decode/issue-stage hazard and forwarding controller.
// Tracks the EX and MEM destination registers plus one long-latency
// multiplier op, and decides forwarding, stalls and the issue strobe
// combinationally from the presented instruction.
module issue_hazard_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int REG_AW  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dec_valid,
  input  logic [REG_AW-1:0] dec_rs1,
  input  logic [REG_AW-1:0] dec_rs2,
  input  logic [REG_AW-1:0] dec_rd,
  input  logic              dec_rs1_used,
  input  logic              dec_rs2_used,
  input  logic              dec_rd_we,
  input  logic              dec_is_load,
  input  logic              dec_is_mul,
  input  logic              flush,
  output logic              issue,
  output logic              stall,
  output logic [1:0]        stall_cause,
  output logic [1:0]        rs1_forwarding_bit,
  output logic [1:0]        rs2_forwarding_bit,
  output logic              mul_busy,
  output logic              mul_wb,
  output logic [REG_AW-1:0] mul_rd
);

  localparam logic [1:0] ST_RUN        = 2'd0;
  localparam logic [1:0] ST_LOAD_STALL = 2'd1;
  localparam logic [1:0] ST_MUL_WAIT   = 2'd2;

  localparam logic [1:0] CAUSE_NONE   = 2'b00;
  localparam logic [1:0] CAUSE_LOAD   = 2'b01;
  localparam logic [1:0] CAUSE_MULDEP = 2'b10;
  localparam logic [1:0] CAUSE_MULSTR = 2'b11;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [REG_AW-1:0] REG_ZERO  = {REG_AW{1'b0}};
  localparam logic [3:0]        MUL_LAT_C = 4'(MUL_LAT);

  // Pipeline scoreboard and multiplier tracking
  logic              ex_v_q, ex_we_q, ex_ld_q, ex_v_d, ex_we_d, ex_ld_d;
  logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
  logic              mem_v_q, mem_we_q, mem_v_d, mem_we_d;
  logic [REG_AW-1:0] mem_rd_q, mem_rd_d;
  logic              mul_busy_q, mul_busy_d;
  logic [REG_AW-1:0] mul_rd_q, mul_rd_d;
  logic [3:0]        mul_cnt_q, mul_cnt_d;
  logic [1:0]        state_q, state_d;

  logic rs1_ex_s, rs1_mem_s, rs2_ex_s, rs2_mem_s;
  logic load_use_s, mul_dep_s, mul_str_s;
  logic [1:0] cause_s;

  // Source-match, stall-cause, forwarding and issue decisions
  always_comb begin
    rs1_ex_s  = dec_rs1_used & (dec_rs1 != REG_ZERO) & ex_v_q  & ex_we_q  & (ex_rd_q  == dec_rs1);
    rs2_ex_s  = dec_rs2_used & (dec_rs2 != REG_ZERO) & ex_v_q  & ex_we_q  & (ex_rd_q  == dec_rs2);
    rs1_mem_s = dec_rs1_used & (dec_rs1 != REG_ZERO) & mem_v_q & mem_we_q & (mem_rd_q == dec_rs1);
    rs2_mem_s = dec_rs2_used & (dec_rs2 != REG_ZERO) & mem_v_q & mem_we_q & (mem_rd_q == dec_rs2);

    mul_str_s = dec_is_mul & mul_busy_q;
    mul_dep_s = mul_busy_q &
                ((dec_rs1_used & (dec_rs1 != REG_ZERO) & (dec_rs1 == mul_rd_q)) |
                 (dec_rs2_used & (dec_rs2 != REG_ZERO) & (dec_rs2 == mul_rd_q)) |
                 (dec_rd_we    & (dec_rd  != REG_ZERO) & (dec_rd  == mul_rd_q)));
    // The stalled load has always left EX by the next cycle, so a second
    // consecutive load-use stall is never legitimate.
    load_use_s = (state_q != ST_LOAD_STALL) & ex_ld_q & (rs1_ex_s | rs2_ex_s);

    if (!dec_valid) begin
      cause_s = CAUSE_NONE;
    end else if (mul_str_s) begin
      cause_s = CAUSE_MULSTR;
    end else if (mul_dep_s) begin
      cause_s = CAUSE_MULDEP;
    end else if (load_use_s) begin
      cause_s = CAUSE_LOAD;
    end else begin
      cause_s = CAUSE_NONE;
    end

    stall_cause = cause_s;
    stall       = (cause_s != CAUSE_NONE);
    issue       = dec_valid & ~stall & ~flush;

    // A load in EX has no data yet, so it never forwards from EX.
    if (!dec_valid) begin
      rs1_forwarding_bit = FWD_RF;
    end else if (rs1_ex_s && !ex_ld_q) begin
      rs1_forwarding_bit = FWD_EX;
    end else if (rs1_mem_s) begin
      rs1_forwarding_bit = FWD_MEM;
    end else begin
      rs1_forwarding_bit = FWD_RF;
    end

    if (!dec_valid) begin
      rs2_forwarding_bit = FWD_RF;
    end else if (rs2_ex_s && !ex_ld_q) begin
      rs2_forwarding_bit = FWD_EX;
    end else if (rs2_mem_s) begin
      rs2_forwarding_bit = FWD_MEM;
    end else begin
      rs2_forwarding_bit = FWD_RF;
    end

    mul_busy = mul_busy_q;
    mul_rd   = mul_rd_q;
    mul_wb   = mul_busy_q & (mul_cnt_q == 4'd1);
  end

  // Next-state for scoreboard, multiplier and FSM
  always_comb begin
    // MEM inherits EX; a flush kills the youngest (EX) entry on its way.
    mem_v_d  = ex_v_q & ~flush;
    mem_rd_d = ex_rd_q;
    mem_we_d = ex_we_q;

    // Only issued non-mul instructions enter EX; everything else is a bubble.
    if (issue && !dec_is_mul) begin
      ex_v_d  = 1'b1;
      ex_rd_d = dec_rd;
      ex_we_d = dec_rd_we;
      ex_ld_d = dec_is_load;
    end else begin
      ex_v_d  = 1'b0;
      ex_rd_d = ex_rd_q;
      ex_we_d = 1'b0;
      ex_ld_d = 1'b0;
    end

    // Flush does not touch the multiplier: the mul is older than the branch.
    if (issue && dec_is_mul) begin
      mul_busy_d = 1'b1;
      mul_rd_d   = dec_rd;
      mul_cnt_d  = MUL_LAT_C;
    end else if (mul_busy_q) begin
      mul_busy_d = (mul_cnt_q != 4'd1);
      mul_rd_d   = mul_rd_q;
      mul_cnt_d  = mul_cnt_q - 4'd1;
    end else begin
      mul_busy_d = 1'b0;
      mul_rd_d   = mul_rd_q;
      mul_cnt_d  = mul_cnt_q;
    end

    if (flush) begin
      state_d = ST_RUN;
    end else begin
      case (cause_s)
        CAUSE_LOAD:   state_d = ST_LOAD_STALL;
        CAUSE_MULDEP: state_d = ST_MUL_WAIT;
        CAUSE_MULSTR: state_d = ST_MUL_WAIT;
        default:      state_d = ST_RUN;
      endcase
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_v_q     <= 1'b0;
      ex_rd_q    <= REG_ZERO;
      ex_we_q    <= 1'b0;
      ex_ld_q    <= 1'b0;
      mem_v_q    <= 1'b0;
      mem_rd_q   <= REG_ZERO;
      mem_we_q   <= 1'b0;
      mul_busy_q <= 1'b0;
      mul_rd_q   <= REG_ZERO;
      mul_cnt_q  <= 4'd0;
      state_q    <= ST_RUN;
    end else begin
      ex_v_q     <= ex_v_d;
      ex_rd_q    <= ex_rd_d;
      ex_we_q    <= ex_we_d;
      ex_ld_q    <= ex_ld_d;
      mem_v_q    <= mem_v_d;
      mem_rd_q   <= mem_rd_d;
      mem_we_q   <= mem_we_d;
      mul_busy_q <= mul_busy_d;
      mul_rd_q   <= mul_rd_d;
      mul_cnt_q  <= mul_cnt_d;
      state_q    <= state_d;
    end
  end

endmodule

// File: tb/tb_issue_hazard_ctrl.sv
// Scoreboard bench for issue_hazard_ctrl (MUL_LAT=4): each step drives one
// decoder cycle, pushes the hand-derived expected outputs, and pops/compares
// them mid-cycle before the next rising edge.
module tb_issue_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       dec_valid;
  logic [4:0] dec_rs1, dec_rs2, dec_rd;
  logic       dec_rs1_used, dec_rs2_used, dec_rd_we, dec_is_load, dec_is_mul;
  logic       flush;
  logic       issue, stall, mul_busy, mul_wb;
  logic [1:0] stall_cause, rs1_forwarding_bit, rs2_forwarding_bit;
  logic [4:0] mul_rd;

  typedef struct packed {
    logic       issue;
    logic       stall;
    logic [1:0] cause;
    logic [1:0] f1;
    logic [1:0] f2;
    logic       busy;
    logic       wb;
    logic [4:0] rd;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   step_no  = 0;

  issue_hazard_ctrl #(.MUL_LAT(4), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .dec_valid(dec_valid),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
    .dec_rs1_used(dec_rs1_used), .dec_rs2_used(dec_rs2_used),
    .dec_rd_we(dec_rd_we), .dec_is_load(dec_is_load), .dec_is_mul(dec_is_mul),
    .flush(flush), .issue(issue), .stall(stall), .stall_cause(stall_cause),
    .rs1_forwarding_bit(rs1_forwarding_bit), .rs2_forwarding_bit(rs2_forwarding_bit),
    .mul_busy(mul_busy), .mul_wb(mul_wb), .mul_rd(mul_rd)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs === expv) begin
      n_pass++;
    end else begin
      $display("FAIL step %0d %s: got %0h expected %0h", step_no, tag, obs, expv);
    end
  endtask

  // One decoder cycle: drive after the rising edge, compare on the falling edge.
  task automatic step(
    input logic r, input logic fl, input logic v,
    input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
    input logic u1, input logic u2, input logic we, input logic ld, input logic mul,
    input logic e_iss, input logic e_stl, input logic [1:0] e_cause,
    input logic [1:0] e_f1, input logic [1:0] e_f2,
    input logic e_busy, input logic e_wb, input logic [4:0] e_rd);
    exp_t e;
    exp_t got;
    @(posedge clk);
    #1;
    rst = r; flush = fl; dec_valid = v;
    dec_rs1 = rs1; dec_rs2 = rs2; dec_rd = rd;
    dec_rs1_used = u1; dec_rs2_used = u2; dec_rd_we = we;
    dec_is_load = ld; dec_is_mul = mul;
    exp_q.push_back({e_iss, e_stl, e_cause, e_f1, e_f2, e_busy, e_wb, e_rd});
    @(negedge clk);
    step_no++;
    e = exp_q.pop_front();
    got = {issue, stall, stall_cause, rs1_forwarding_bit, rs2_forwarding_bit, mul_busy, mul_wb, mul_rd};
    check_eq("issue",    32'(got.issue), 32'(e.issue));
    check_eq("stall",    32'(got.stall), 32'(e.stall));
    check_eq("cause",    32'(got.cause), 32'(e.cause));
    check_eq("rs1_fwd",  32'(got.f1),    32'(e.f1));
    check_eq("rs2_fwd",  32'(got.f2),    32'(e.f2));
    check_eq("mul_busy", 32'(got.busy),  32'(e.busy));
    check_eq("mul_wb",   32'(got.wb),    32'(e.wb));
    check_eq("mul_rd",   32'(got.rd),    32'(e.rd));
  endtask

  task automatic idle(input logic r, input logic e_busy, input logic e_wb, input logic [4:0] e_rd);
    step(r, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
         1'b0, 1'b0, 2'b00, 2'b00, 2'b00, e_busy, e_wb, e_rd);
  endtask

  // Stimulus sequence
  initial begin
    rst = 1'b1; flush = 1'b0; dec_valid = 1'b0;
    dec_rs1 = 5'd0; dec_rs2 = 5'd0; dec_rd = 5'd0;
    dec_rs1_used = 1'b0; dec_rs2_used = 1'b0; dec_rd_we = 1'b0;
    dec_is_load = 1'b0; dec_is_mul = 1'b0;
    repeat (2) @(posedge clk);

    // reset state
    idle(1'b0, 1'b0, 1'b0, 5'd0);

    // EX then MEM forwarding: args r fl v rs1 rs2 rd u1 u2 we ld mul | iss stl cause f1 f2 busy wb rd
    step(0,0,1, 5'd1, 5'd2, 5'd3, 1,1,1,0,0,  1,0,2'b00,2'b00,2'b00, 0,0,5'd0); // add x3,x1,x2
    step(0,0,1, 5'd3, 5'd1, 5'd4, 1,1,1,0,0,  1,0,2'b00,2'b01,2'b00, 0,0,5'd0); // sub x4,x3,x1
    step(0,0,1, 5'd3, 5'd0, 5'd5, 1,1,1,0,0,  1,0,2'b00,2'b10,2'b00, 0,0,5'd0); // or x5,x3,x0
    idle(1'b0, 1'b0, 1'b0, 5'd0);

    // load-use: one stall cycle, then MEM forwarding on both sources
    step(0,0,1, 5'd1, 5'd0, 5'd6, 1,0,1,1,0,  1,0,2'b00,2'b00,2'b00, 0,0,5'd0); // lw x6
    step(0,0,1, 5'd6, 5'd6, 5'd7, 1,1,1,0,0,  0,1,2'b01,2'b00,2'b00, 0,0,5'd0); // add x7,x6,x6
    step(0,0,1, 5'd6, 5'd6, 5'd7, 1,1,1,0,0,  1,0,2'b00,2'b10,2'b10, 0,0,5'd0);
    idle(1'b0, 1'b0, 1'b0, 5'd0);

    // mul dependency: 4 stall cycles, wb in the 4th, issue in the 5th
    step(0,0,1, 5'd1, 5'd2, 5'd8, 1,1,1,0,1,  1,0,2'b00,2'b00,2'b00, 0,0,5'd0); // mul x8
    step(0,0,1, 5'd8, 5'd1, 5'd9, 1,1,1,0,0,  0,1,2'b10,2'b00,2'b00, 1,0,5'd8); // add x9,x8,x1
    step(0,0,1, 5'd8, 5'd1, 5'd9, 1,1,1,0,0,  0,1,2'b10,2'b00,2'b00, 1,0,5'd8);
    step(0,0,1, 5'd8, 5'd1, 5'd9, 1,1,1,0,0,  0,1,2'b10,2'b00,2'b00, 1,0,5'd8);
    step(0,0,1, 5'd8, 5'd1, 5'd9, 1,1,1,0,0,  0,1,2'b10,2'b00,2'b00, 1,1,5'd8);
    step(0,0,1, 5'd8, 5'd1, 5'd9, 1,1,1,0,0,  1,0,2'b00,2'b00,2'b00, 0,0,5'd8);
    idle(1'b0, 1'b0, 1'b0, 5'd8);

    // structural stall and WAW dependency on the mul destination
    step(0,0,1, 5'd1, 5'd2, 5'd8, 1,1,1,0,1,  1,0,2'b00,2'b00,2'b00, 0,0,5'd8); // mul x8
    step(0,0,1, 5'd1, 5'd2, 5'd10,1,1,1,0,1,  0,1,2'b11,2'b00,2'b00, 1,0,5'd8); // mul x10
    step(0,0,1, 5'd1, 5'd2, 5'd8, 1,1,1,0,0,  0,1,2'b10,2'b00,2'b00, 1,0,5'd8); // add x8 (WAW)
    step(0,0,1, 5'd1, 5'd2, 5'd10,1,1,1,0,1,  0,1,2'b11,2'b00,2'b00, 1,0,5'd8);
    step(0,0,1, 5'd1, 5'd2, 5'd10,1,1,1,0,1,  0,1,2'b11,2'b00,2'b00, 1,1,5'd8);
    step(0,0,1, 5'd1, 5'd2, 5'd10,1,1,1,0,1,  1,0,2'b00,2'b00,2'b00, 0,0,5'd8);
    idle(1'b0, 1'b1, 1'b0, 5'd10);
    idle(1'b0, 1'b1, 1'b0, 5'd10);
    idle(1'b0, 1'b1, 1'b0, 5'd10);
    idle(1'b0, 1'b1, 1'b1, 5'd10);

    // flush kills the EX entry; re-presented consumer reads the regfile
    step(0,0,1, 5'd1, 5'd2, 5'd3, 1,1,1,0,0,  1,0,2'b00,2'b00,2'b00, 0,0,5'd10); // add x3
    step(0,1,1, 5'd3, 5'd1, 5'd4, 1,1,1,0,0,  0,0,2'b00,2'b01,2'b00, 0,0,5'd10); // sub + flush
    step(0,0,1, 5'd3, 5'd1, 5'd4, 1,1,1,0,0,  1,0,2'b00,2'b00,2'b00, 0,0,5'd10);

    // flush during a load-use stall: killed load never forwards or stalls
    step(0,0,1, 5'd1, 5'd0, 5'd6, 1,0,1,1,0,  1,0,2'b00,2'b00,2'b00, 0,0,5'd10); // lw x6
    step(0,1,1, 5'd6, 5'd6, 5'd7, 1,1,1,0,0,  0,1,2'b01,2'b00,2'b00, 0,0,5'd10); // add + flush
    step(0,0,1, 5'd6, 5'd6, 5'd7, 1,1,1,0,0,  1,0,2'b00,2'b00,2'b00, 0,0,5'd10);

    // x0 destination never forwards
    step(0,0,1, 5'd1, 5'd2, 5'd0, 1,1,1,0,0,  1,0,2'b00,2'b00,2'b00, 0,0,5'd10); // add x0
    step(0,0,1, 5'd0, 5'd0, 5'd4, 1,1,1,0,0,  1,0,2'b00,2'b00,2'b00, 0,0,5'd10); // sub x4,x0,x0

    // reset during MUL_WAIT discards the mul; no write-back afterwards
    step(0,0,1, 5'd1, 5'd2, 5'd12,1,1,1,0,1,  1,0,2'b00,2'b00,2'b00, 0,0,5'd10); // mul x12
    step(0,0,1, 5'd12,5'd1, 5'd13,1,1,1,0,0,  0,1,2'b10,2'b00,2'b00, 1,0,5'd12); // add x13
    step(1,0,1, 5'd12,5'd1, 5'd13,1,1,1,0,0,  0,1,2'b10,2'b00,2'b00, 1,0,5'd12); // rst sampled
    idle(1'b0, 1'b0, 1'b0, 5'd0);
    idle(1'b0, 1'b0, 1'b0, 5'd0);
    idle(1'b0, 1'b0, 1'b0, 5'd0);
    idle(1'b0, 1'b0, 1'b0, 5'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
